// File: rtl/note_sequencer.sv
// Plays 4-slot note frames from the MCU: synchronises the ce handshake, buffers up to two
// frames, and steps each slot's pitch for its duration in ticks.
module note_sequencer #(
  parameter int NSLOTS = 4,
  parameter int SLOTW  = 10,
  parameter int DURW   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic [NSLOTS*SLOTW-1:0] flattenedMCUout,
  input  logic                    tick,
  output logic                    makingMusic,
  output logic                    start,
  output logic [SLOTW-DURW-1:0]   pitch,
  output logic                    frameReq,
  output logic                    overflow
);
  localparam int FW = NSLOTS * SLOTW;
  localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t state, state_nx;

  logic          ce_s1, ce_s2, ce_s3;
  logic          capture;
  logic [FW-1:0] fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;
  logic          push, pop, fifo_has;
  logic [FW-1:0] head;

  logic [FW-1:0]    play_reg, play_nx;
  logic [IW-1:0]    slot, slot_nx;
  logic [DURW-1:0]  counter, cnt_nx;
  logic [SLOTW-1:0] cur_slot;
  logic [DURW-1:0]  cur_dur;
  logic             end_frame;

  // ce_s3 is only an edge detector stage; capture fires when the synchronised ce drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_s1 <= 1'b0;
      ce_s2 <= 1'b0;
      ce_s3 <= 1'b0;
    end else begin
      ce_s1 <= ce;
      ce_s2 <= ce_s1;
      ce_s3 <= ce_s2;
    end
  end

  assign capture  = ce_s3 & ~ce_s2;
  assign fifo_has = (count != 2'd0);
  assign head     = fifo_mem[rd_ptr];
  assign push     = capture & ((count != 2'd2) | pop);
  assign frameReq = (count != 2'd2);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= flattenedMCUout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
      if (capture && !push) overflow <= 1'b1;
    end
  end

  assign cur_slot = play_reg[int'(slot)*SLOTW +: SLOTW];
  assign cur_dur  = cur_slot[DURW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      play_reg <= '0;
      slot     <= '0;
      counter  <= '0;
    end else begin
      state    <= state_nx;
      play_reg <= play_nx;
      slot     <= slot_nx;
      counter  <= cnt_nx;
    end
  end

  // A frame ending with data waiting chains straight into LOAD so playback stays continuous
  always_comb begin
    state_nx  = state;
    play_nx   = play_reg;
    slot_nx   = slot;
    cnt_nx    = counter;
    pop       = 1'b0;
    start     = 1'b0;
    end_frame = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_has) begin
          pop      = 1'b1;
          play_nx  = head;
          slot_nx  = '0;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (cur_dur != '0) begin
          start    = 1'b1;
          cnt_nx   = cur_dur;
          state_nx = PLAY;
        end else begin
          end_frame = 1'b1;
        end
      end
      PLAY: begin
        if (tick) begin
          cnt_nx = counter - DURW'(1);
          if (counter == DURW'(1)) begin
            if (slot != IW'(NSLOTS - 1)) begin
              slot_nx  = slot + IW'(1);
              state_nx = LOAD;
            end else begin
              end_frame = 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (end_frame) begin
      if (fifo_has) begin
        pop      = 1'b1;
        play_nx  = head;
        slot_nx  = '0;
        state_nx = LOAD;
      end else begin
        slot_nx  = '0;
        state_nx = IDLE;
      end
    end
  end

  assign makingMusic = (state != IDLE);
  assign pitch       = (state == IDLE) ? '0 : cur_slot[SLOTW-1:DURW];

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios with literal expectations plus randomized
// frames, all checked every cycle against a queue-based playback model.
module tb_note_sequencer;
  localparam int NSLOTS = 4;
  localparam int SLOTW  = 10;
  localparam int FW     = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic [FW-1:0] flattenedMCUout;
  logic          tick;
  logic          makingMusic;
  logic          start;
  logic [5:0]    pitch;
  logic          frameReq;
  logic          overflow;

  always #5 clk = ~clk;

  note_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .ce(ce),
    .flattenedMCUout(flattenedMCUout),
    .tick(tick),
    .makingMusic(makingMusic),
    .start(start),
    .pitch(pitch),
    .frameReq(frameReq),
    .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  int mmCycles, startCount, playTicks, mmFalls;
  int startPitches[$];
  bit mmPrev;

  logic [FW-1:0] mq[$];
  logic [FW-1:0] mFrame;
  int            mSlot, mRemain;
  bit            mActive, mLoad, mOvf;
  bit [2:0]      ceHist;

  function automatic logic [9:0] slotOf(input logic [FW-1:0] f, input int k);
    return f[k*SLOTW +: SLOTW];
  endfunction

  // Model: frames wait in a queue, the player walks slots and counts ticks down
  task automatic modelReset();
    mq.delete();
    mFrame  = '0;
    mSlot   = 0;
    mRemain = 0;
    mActive = 1'b0;
    mLoad   = 1'b0;
    mOvf    = 1'b0;
    ceHist  = '0;
  endtask

  task automatic modelNextFrame();
    if (mq.size() > 0) begin
      mFrame = mq.pop_front();
      mSlot  = 0;
      mLoad  = 1'b1;
    end else begin
      mActive = 1'b0;
      mLoad   = 1'b0;
    end
  endtask

  task automatic modelStep();
    bit cap;
    logic [9:0] s;
    cap = ceHist[2] && !ceHist[1];
    ceHist = {ceHist[1:0], ce};
    if (!mActive) begin
      if (mq.size() > 0) begin
        mFrame  = mq.pop_front();
        mSlot   = 0;
        mActive = 1'b1;
        mLoad   = 1'b1;
      end
    end else if (mLoad) begin
      s = slotOf(mFrame, mSlot);
      if (s[3:0] != 4'd0) begin
        mRemain = int'(s[3:0]);
        mLoad   = 1'b0;
      end else begin
        modelNextFrame();
      end
    end else if (tick) begin
      mRemain = mRemain - 1;
      if (mRemain == 0) begin
        if (mSlot < NSLOTS - 1) begin
          mSlot = mSlot + 1;
          mLoad = 1'b1;
        end else begin
          modelNextFrame();
        end
      end
    end
    if (cap) begin
      if (mq.size() < 2) mq.push_back(flattenedMCUout);
      else mOvf = 1'b1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) modelReset();
    else modelStep();
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: compare against the model, collect stats, drive tick for next edge
  task automatic applyStimulus(input bit t);
    logic [9:0] s;
    s = slotOf(mFrame, mSlot);
    checkOutput("makingMusic", 8'(makingMusic), 8'(mActive));
    checkOutput("start", 8'(start), 8'(mActive && mLoad && (s[3:0] != 4'd0)));
    checkOutput("pitch", 8'(pitch), mActive ? 8'(s[9:4]) : 8'd0);
    checkOutput("frameReq", 8'(frameReq), 8'(mq.size() < 2));
    checkOutput("overflow", 8'(overflow), 8'(mOvf));
    if (makingMusic) mmCycles++;
    if (start) begin
      startCount++;
      startPitches.push_back(int'(pitch));
    end
    if (t && makingMusic && !start) playTicks++;
    if (mmPrev && !makingMusic) mmFalls++;
    mmPrev = makingMusic;
    tick = t;
    @(negedge clk);
  endtask

  task automatic clearStats();
    mmCycles   = 0;
    startCount = 0;
    playTicks  = 0;
    mmFalls    = 0;
    mmPrev     = 1'b0;
    startPitches.delete();
  endtask

  task automatic sendFrame(input logic [FW-1:0] f, input bit rt);
    flattenedMCUout = f;
    ce = 1'b1;
    repeat (2) applyStimulus(rt ? ($urandom_range(0, 3) != 0) : 1'b0);
    ce = 1'b0;
    repeat (4) applyStimulus(rt ? ($urandom_range(0, 3) != 0) : 1'b0);
  endtask

  function automatic logic [FW-1:0] randomFrame();
    logic [FW-1:0] f;
    logic [3:0] d;
    for (int k = 0; k < NSLOTS; k++) begin
      d = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      f[k*SLOTW +: SLOTW] = {6'($urandom_range(0, 63)), d};
    end
    return f;
  endfunction

  function automatic logic [7:0] pitchAt(input int i);
    return (i < startPitches.size()) ? 8'(startPitches[i]) : 8'hff;
  endfunction

  initial begin
    reset_n = 1'b0;
    ce = 1'b0;
    tick = 1'b0;
    flattenedMCUout = '0;
    clearStats();
    @(negedge clk);
    checkOutput("rst_makingMusic", 8'(makingMusic), 8'd0);
    checkOutput("rst_start", 8'(start), 8'd0);
    checkOutput("rst_pitch", 8'(pitch), 8'd0);
    checkOutput("rst_frameReq", 8'(frameReq), 8'd1);
    checkOutput("rst_overflow", 8'(overflow), 8'd0);
    repeat (2) applyStimulus(1'b0);
    reset_n = 1'b1;
    repeat (2) applyStimulus(1'b0);

    $display("[TB] single note frame");
    clearStats();
    sendFrame(40'h00_0000_0052, 1'b0);
    for (int i = 0; i < 20 && !start; i++) applyStimulus(1'b0);
    checkOutput("a_start", 8'(start), 8'd1);
    checkOutput("a_pitch", 8'(pitch), 8'd5);
    checkOutput("a_model_frame", mFrame[7:0], 8'h52);
    applyStimulus(1'b0);
    checkOutput("a_start_single", 8'(start), 8'd0);
    checkOutput("a_pitch_hold", 8'(pitch), 8'd5);
    applyStimulus(1'b1);
    checkOutput("a_mm_after_tick1", 8'(makingMusic), 8'd1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("a_mm_end", 8'(makingMusic), 8'd0);
    checkOutput("a_pitch_end", 8'(pitch), 8'd0);

    $display("[TB] four slot frame");
    clearStats();
    sendFrame({10'h041, 10'h033, 10'h022, 10'h011}, 1'b0);
    for (int i = 0; i < 80; i++) applyStimulus(i % 3 != 0);
    checkOutput("b_starts", 8'(startCount), 8'd4);
    for (int i = 0; i < 4; i++) checkOutput("b_pitch_seq", pitchAt(i), 8'(i + 1));
    checkOutput("b_play_ticks", 8'(playTicks), 8'd7);
    checkOutput("b_mm_falls", 8'(mmFalls), 8'd1);

    $display("[TB] buffering and overflow");
    clearStats();
    sendFrame(40'h7F, 1'b0);
    sendFrame(40'h91, 1'b0);
    checkOutput("c_frameReq_one", 8'(frameReq), 8'd1);
    sendFrame(40'hA2, 1'b0);
    checkOutput("c_frameReq_full", 8'(frameReq), 8'd0);
    checkOutput("c_overflow_before", 8'(overflow), 8'd0);
    sendFrame(40'hB3, 1'b0);
    checkOutput("c_overflow_set", 8'(overflow), 8'd1);
    for (int i = 0; i < 60; i++) applyStimulus(1'b1);
    checkOutput("c_starts", 8'(startCount), 8'd3);
    checkOutput("c_pitch0", pitchAt(0), 8'd7);
    checkOutput("c_pitch1", pitchAt(1), 8'd9);
    checkOutput("c_pitch2", pitchAt(2), 8'd10);
    checkOutput("c_mm_falls", 8'(mmFalls), 8'd1);
    checkOutput("c_overflow_sticky", 8'(overflow), 8'd1);

    $display("[TB] empty frame");
    clearStats();
    sendFrame(40'h30, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0);
    checkOutput("d_mm_cycles", 8'(mmCycles), 8'd1);
    checkOutput("d_starts", 8'(startCount), 8'd0);

    $display("[TB] reset during playback");
    sendFrame(40'h7F, 1'b0);
    sendFrame(40'h11, 1'b0);
    repeat (3) applyStimulus(1'b1);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("e_makingMusic", 8'(makingMusic), 8'd0);
    checkOutput("e_start", 8'(start), 8'd0);
    checkOutput("e_pitch", 8'(pitch), 8'd0);
    checkOutput("e_frameReq", 8'(frameReq), 8'd1);
    checkOutput("e_overflow", 8'(overflow), 8'd0);
    @(negedge clk);
    repeat (2) applyStimulus(1'b0);
    reset_n = 1'b1;
    clearStats();
    for (int i = 0; i < 30; i++) applyStimulus(1'b1);
    checkOutput("e_no_starts", 8'(startCount), 8'd0);
    checkOutput("e_no_music", 8'(mmCycles), 8'd0);

    $display("[TB] randomized frames");
    for (int n = 0; n < 150; n++) begin
      sendFrame(randomFrame(), 1'b1);
      repeat ($urandom_range(0, 40)) applyStimulus($urandom_range(0, 3) != 0);
      if (n == 60) begin
        #3 reset_n = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1);
        reset_n = 1'b1;
      end
    end
    repeat (400) applyStimulus($urandom_range(0, 3) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
